hbm_cmd_unpacker: RTL and testbench



---
 rtl/hbm_cmd_unpacker.sv | 189 ++++++++++++++++++
 tb/tb_hbm_cmd_unpacker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_cmd_unpacker.sv
// hbm_cmd_unpacker
//   Pops packed command words (4 x 32-bit slots) together with their 1024-bit
//   write-data words from the command FIFOs and replays them to the HBM
//   adapter as two commands per dfi clock: slots 0/1 (upper halves) first,
//   then slots 2/3 (lower halves). A NOP pair (all-ones command field) is
//   inserted whenever the next word is not already in flight.
//
// Ports
//   clk, rst         dfi clock, synchronous active-high reset
//   en               allow new FIFO reads
//   cmd_fifo_empty   command FIFO empty
//   cmd_fifo_rd_en   pop strobe shared by the command and write-data FIFOs
//   cmd_fifo_dout    packed command word, valid the cycle after rd_en
//   wr_fifo_dout     write-data word, popped with the same rd_en
//   out_valid        slot outputs carry a real command pair
//   out_cmd/row/col/ba/pc/ch  slot pair fields, slot A in the LSBs
//   out_wrdata       write data for the current pair
//   busy             FSM not idle
//
// Optional build macro HBM_CMD_UNPACK_CHK_EN adds:
//   err_ch_mismatch  sticky flag: a captured word's four channel ids differ
//   underrun_cnt     saturating count of bubbles taken while en=1
module hbm_cmd_unpacker #(
    parameter int CH_W  = 3,
    parameter int PC_W  = 1,
    parameter int BA_W  = 4,
    parameter int COL_W = 6,
    parameter int ROW_W = 14,
    parameter int CMD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cmd_fifo_empty,
    output logic                 cmd_fifo_rd_en,
    input  logic [127:0]         cmd_fifo_dout,
    input  logic [1023:0]        wr_fifo_dout,
    output logic                 out_valid,
    output logic [2*CMD_W-1:0]   out_cmd,
    output logic [2*ROW_W-1:0]   out_row,
    output logic [2*COL_W-1:0]   out_col,
    output logic [2*BA_W-1:0]    out_ba,
    output logic [2*PC_W-1:0]    out_pc,
    output logic [2*CH_W-1:0]    out_ch,
    output logic [511:0]         out_wrdata,
    output logic                 busy
`ifdef HBM_CMD_UNPACK_CHK_EN
    ,
    output logic                 err_ch_mismatch,
    output logic [15:0]          underrun_cnt
`endif
);

    // Field offsets inside one 64-bit half word (LSB first: cmd, row, col, ba, pc, ch).
    localparam int OFF_ROW = 2*CMD_W;
    localparam int OFF_COL = OFF_ROW + 2*ROW_W;
    localparam int OFF_BA  = OFF_COL + 2*COL_W;
    localparam int OFF_PC  = OFF_BA  + 2*BA_W;
    localparam int OFF_CH  = OFF_PC  + 2*PC_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HI, S_LO} state_t;
    typedef enum logic [1:0] {LD_HOLD, LD_UPPER, LD_LOWER, LD_BUBBLE} load_t;

    state_t        state_r, state_nxt;
    load_t         ld;
    logic          pend_r, pend_nxt;
    logic          can_rd;
    logic [63:0]   word_cmd_r;     // lower command half, replayed in S_HI->S_LO
    logic [511:0]  word_wr_r;      // lower write-data half
    logic [63:0]   half;
    logic [511:0]  half_wr;

    assign can_rd = en & ~cmd_fifo_empty & ~rst;
    assign busy   = (state_r != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            pend_r  <= pend_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: if (can_rd) state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_HI;
            S_HI:   state_nxt = S_LO;
            S_LO: begin
                if (pend_r)      state_nxt = S_HI;
                else if (can_rd) state_nxt = S_WAIT;
                else             state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode. The read strobe is decoded from the state
    // register so the popped word lands exactly in S_WAIT or in the S_LO
    // cycle that follows a prefetch.
    always_comb begin
        cmd_fifo_rd_en = 1'b0;
        ld             = LD_HOLD;
        pend_nxt       = pend_r;
        case (state_r)
            S_IDLE: cmd_fifo_rd_en = can_rd;
            S_WAIT: ld = LD_UPPER;
            S_HI: begin
                ld             = LD_LOWER;
                cmd_fifo_rd_en = can_rd;
                pend_nxt       = can_rd;
            end
            S_LO: begin
                if (pend_r) begin
                    ld       = LD_UPPER;
                    pend_nxt = 1'b0;
                end else begin
                    ld             = LD_BUBBLE;
                    cmd_fifo_rd_en = can_rd;
                end
            end
            default: ;
        endcase
    end

    // Upper half is taken straight from the FIFO outputs in the capture cycle;
    // only the lower half needs to be held for the following cycle.
    assign half    = (ld == LD_UPPER) ? cmd_fifo_dout[127:64]   : word_cmd_r;
    assign half_wr = (ld == LD_UPPER) ? wr_fifo_dout[1023:512]  : word_wr_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cmd_r <= '0;
            word_wr_r  <= '0;
            out_valid  <= 1'b0;
            out_cmd    <= '1;
            out_row    <= '0;
            out_col    <= '0;
            out_ba     <= '0;
            out_pc     <= '0;
            out_ch     <= '0;
            out_wrdata <= '0;
        end else begin
            if (ld == LD_UPPER) begin
                word_cmd_r <= cmd_fifo_dout[63:0];
                word_wr_r  <= wr_fifo_dout[511:0];
            end
            if (ld == LD_UPPER || ld == LD_LOWER) begin
                out_valid  <= 1'b1;
                out_cmd    <= half[0       +: 2*CMD_W];
                out_row    <= half[OFF_ROW +: 2*ROW_W];
                out_col    <= half[OFF_COL +: 2*COL_W];
                out_ba     <= half[OFF_BA  +: 2*BA_W];
                out_pc     <= half[OFF_PC  +: 2*PC_W];
                out_ch     <= half[OFF_CH  +: 2*CH_W];
                out_wrdata <= half_wr;
            end else if (ld == LD_BUBBLE) begin
                out_valid <= 1'b0;
                out_cmd   <= '1;
            end
        end
    end

`ifdef HBM_CMD_UNPACK_CHK_EN
    logic [CH_W-1:0] ch0, ch1, ch2, ch3;
    assign ch0 = cmd_fifo_dout[64 + OFF_CH        +: CH_W];
    assign ch1 = cmd_fifo_dout[64 + OFF_CH + CH_W +: CH_W];
    assign ch2 = cmd_fifo_dout[OFF_CH             +: CH_W];
    assign ch3 = cmd_fifo_dout[OFF_CH + CH_W      +: CH_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ch_mismatch <= 1'b0;
            underrun_cnt    <= '0;
        end else begin
            if (ld == LD_UPPER && (ch0 != ch1 || ch0 != ch2 || ch0 != ch3))
                err_ch_mismatch <= 1'b1;
            if (ld == LD_BUBBLE && en && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hbm_cmd_unpacker.sv
// Directed bench for hbm_cmd_unpacker: a single-word cycle table followed by
// multi-cycle sequences (back-to-back, empty/refill, en drop, reset in S_WAIT).
// A behavioural FIFO supplies word k on the k-th pop; expected slot fields are
// generated from per-slot field functions.
module tb_hbm_cmd_unpacker;

    localparam int BADK = 13;   // word whose slot 3 carries a different channel id

    logic           clk = 1'b0;
    logic           rst, en;
    logic           cmd_fifo_empty, cmd_fifo_rd_en;
    logic [127:0]   cmd_fifo_dout;
    logic [1023:0]  wr_fifo_dout;
    logic           out_valid;
    logic [7:0]     out_cmd;
    logic [27:0]    out_row;
    logic [11:0]    out_col;
    logic [7:0]     out_ba;
    logic [1:0]     out_pc;
    logic [5:0]     out_ch;
    logic [511:0]   out_wrdata;
    logic           busy;
`ifdef HBM_CMD_UNPACK_CHK_EN
    logic           err_ch_mismatch;
    logic [15:0]    underrun_cnt;
`endif

    int pushed = 0;
    int popped = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hbm_cmd_unpacker #(.CH_W(3), .PC_W(1), .BA_W(4), .COL_W(6), .ROW_W(14), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_rd_en(cmd_fifo_rd_en),
        .cmd_fifo_dout(cmd_fifo_dout), .wr_fifo_dout(wr_fifo_dout),
        .out_valid(out_valid), .out_cmd(out_cmd), .out_row(out_row),
        .out_col(out_col), .out_ba(out_ba), .out_pc(out_pc), .out_ch(out_ch),
        .out_wrdata(out_wrdata), .busy(busy)
`ifdef HBM_CMD_UNPACK_CHK_EN
        , .err_ch_mismatch(err_ch_mismatch), .underrun_cnt(underrun_cnt)
`endif
    );

    // Per-slot field values of word k, slot s
    function automatic logic [3:0]  f_cmd(int k, int s); return 4'(k + s);           endfunction
    function automatic logic [13:0] f_row(int k, int s); return 14'(k*16 + s + 100); endfunction
    function automatic logic [5:0]  f_col(int k, int s); return 6'(k*4 + s);         endfunction
    function automatic logic [3:0]  f_ba (int k, int s); return 4'(k + 3*s);         endfunction
    function automatic logic [0:0]  f_pc (int k, int s); return 1'((k ^ s) & 1);     endfunction
    function automatic logic [2:0]  f_ch (int k, int s);
        if (k == BADK && s == 3) return 3'd4;
        return 3'(k);
    endfunction

    // Packed half: chB,chA,pcB,pcA,baB,baA,colB,colA,rowB,rowA,cmdB,cmdA
    function automatic logic [63:0] pack_half(int k, int sa);
        int sb;
        sb = sa + 1;
        return {f_ch(k,sb), f_ch(k,sa), f_pc(k,sb), f_pc(k,sa), f_ba(k,sb), f_ba(k,sa),
                f_col(k,sb), f_col(k,sa), f_row(k,sb), f_row(k,sa), f_cmd(k,sb), f_cmd(k,sa)};
    endfunction

    function automatic logic [511:0] wr_half(int k, bit lo);
        logic [31:0] x;
        x = (lo ? 32'h5A00_0000 : 32'hA500_0000) | 32'(k);
        return {16{x}};
    endfunction

    // Behavioural FIFO pair with one-cycle read latency
    assign cmd_fifo_empty = (pushed == popped);
    always @(posedge clk) begin
        if (cmd_fifo_rd_en) begin
            cmd_fifo_dout <= {pack_half(popped, 0), pack_half(popped, 2)};
            wr_fifo_dout  <= {wr_half(popped, 1'b0), wr_half(popped, 1'b1)};
            popped        <= popped + 1;
        end
    end

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_pair(input int k, input bit lo);
        int a, b;
        logic [63:0]  e, g;
        logic [511:0] ew;
        a  = lo ? 2 : 0;
        b  = a + 1;
        e  = {f_cmd(k,b), f_cmd(k,a), f_row(k,b), f_row(k,a), f_col(k,b), f_col(k,a),
              f_ba(k,b), f_ba(k,a), f_pc(k,b), f_pc(k,a), f_ch(k,b), f_ch(k,a)};
        g  = {out_cmd, out_row, out_col, out_ba, out_pc, out_ch};
        ew = wr_half(k, lo);
        chk(g == e, "pair_fields", g, e);
        chk(out_wrdata == ew, "wrdata", out_wrdata[63:0], ew[63:0]);
    endtask

    task automatic check_reset(input string nm);
        chk(out_valid == 1'b0, {nm, "_valid"}, 64'(out_valid), 64'd0);
        chk(out_cmd == 8'hFF, {nm, "_cmd"}, 64'(out_cmd), 64'hFF);
        chk({out_row, out_col, out_ba, out_pc, out_ch} == 56'd0, {nm, "_fields"},
            64'({out_row, out_col, out_ba, out_pc, out_ch}), 64'd0);
        chk(out_wrdata == '0, {nm, "_wrdata"}, out_wrdata[63:0], 64'd0);
        chk(busy == 1'b0, {nm, "_busy"}, 64'(busy), 64'd0);
        chk(cmd_fifo_rd_en == 1'b0, {nm, "_rd_en"}, 64'(cmd_fifo_rd_en), 64'd0);
`ifdef HBM_CMD_UNPACK_CHK_EN
        chk(err_ch_mismatch == 1'b0, {nm, "_err"}, 64'(err_ch_mismatch), 64'd0);
        chk(underrun_cnt == 16'd0, {nm, "_underrun"}, 64'(underrun_cnt), 64'd0);
`endif
    endtask

    // Runs ncyc cycles from the current cycle (called at posedge+1).
    // Checks every valid pair in pop order, NOP command on every idle cycle,
    // and the rd_en / out_valid cycle masks at the end.
    task automatic run(input string nm, input int ncyc, input int p0_at, input int p0_n,
                       input int p1_at, input int p1_n, input int drop_at, input int rst_at,
                       input logic [31:0] exp_rd, input logic [31:0] exp_vld);
        logic [31:0] rdm, vm;
        int k;
        bit lo;
        rdm = '0;
        vm  = '0;
        k   = popped;
        lo  = 1'b0;
        en  = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == p0_at)   pushed += p0_n;
            if (c == p1_at)   pushed += p1_n;
            if (c == drop_at) en = 1'b0;
            rst = (c == rst_at);
            @(negedge clk);
            rdm[c] = cmd_fifo_rd_en;
            vm[c]  = out_valid;
            if (cmd_fifo_rd_en)
                chk(!cmd_fifo_empty && !rst, {nm, "_rd_guard"}, 64'({cmd_fifo_empty, rst}), 64'd0);
            if (out_valid) begin
                check_pair(k, lo);
                if (lo) k++;
                lo = !lo;
            end else begin
                chk(out_cmd == 8'hFF, {nm, "_nop_cmd"}, 64'(out_cmd), 64'hFF);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        chk(rdm == exp_rd,  {nm, "_rd_mask"},    64'(rdm), 64'(exp_rd));
        chk(vm  == exp_vld, {nm, "_valid_mask"}, 64'(vm),  64'(exp_vld));
    endtask

    typedef struct {
        logic       en_i;
        logic       exp_rd;
        logic       exp_vld;
        logic [7:0] exp_cmd;
        logic       exp_busy;
        int         wsel;     // 0: no data check, 1: upper pair of word 0, 2: lower pair
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h32, 1'b1, 2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 0};

        // Reset held with data available and en=1: no pop may happen
        rst    = 1'b1;
        en     = 1'b1;
        pushed = 1;
        repeat (3) begin
            @(negedge clk);
            chk(cmd_fifo_rd_en == 1'b0, "rd_in_reset", 64'(cmd_fifo_rd_en), 64'd0);
        end
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word, FIFO empty after one pop
        for (int i = 0; i < 6; i++) begin
            en = tbl[i].en_i;
            @(negedge clk);
            chk(cmd_fifo_rd_en == tbl[i].exp_rd,   "single_rd_en", 64'(cmd_fifo_rd_en), 64'(tbl[i].exp_rd));
            chk(out_valid      == tbl[i].exp_vld,  "single_valid", 64'(out_valid),      64'(tbl[i].exp_vld));
            chk(out_cmd        == tbl[i].exp_cmd,  "single_cmd",   64'(out_cmd),        64'(tbl[i].exp_cmd));
            chk(busy           == tbl[i].exp_busy, "single_busy",  64'(busy),           64'(tbl[i].exp_busy));
            if (tbl[i].wsel != 0) check_pair(0, tbl[i].wsel == 2);
            @(posedge clk); #1;
        end

        // Four words back-to-back: rd_en at t0,t2,t4,t6; valid t2..t9
        run("b2b", 12, 0, 4, -1, 0, -1, -1, 32'h55, 32'h3FC);

        // Empty during HI of 2nd word, refill at t7
        run("refill", 12, 0, 2, 7, 1, -1, -1, 32'h85, 32'h63C);

        // en dropped in HI of 2nd word; one word left in FIFO and never read
        run("en_drop", 10, 0, 3, -1, 0, 4, -1, 32'h5, 32'h3C);
        @(negedge clk);
        chk(busy == 1'b0, "en_drop_idle", 64'(busy), 64'd0);
        chk(cmd_fifo_rd_en == 1'b0, "en_drop_no_rd", 64'(cmd_fifo_rd_en), 64'd0);
        @(posedge clk); #1;

        // Reset during S_WAIT: popped word is discarded
        run("rst_wait", 2, -1, 0, -1, 0, -1, 1, 32'h1, 32'h0);
        @(negedge clk);
        check_reset("rst_wait");
        @(posedge clk); #1;

        run("post_rst", 6, 0, 1, -1, 0, -1, -1, 32'h1, 32'hC);
        run("single_a", 6, 0, 1, -1, 0, -1, -1, 32'h1, 32'hC);
`ifdef HBM_CMD_UNPACK_CHK_EN
        chk(err_ch_mismatch == 1'b0, "err_before_bad", 64'(err_ch_mismatch), 64'd0);
`endif
        run("single_bad", 6, 0, 1, -1, 0, -1, -1, 32'h1, 32'hC);
`ifdef HBM_CMD_UNPACK_CHK_EN
        chk(err_ch_mismatch == 1'b1, "err_set", 64'(err_ch_mismatch), 64'd1);
        chk(underrun_cnt == 16'd3, "underrun_3", 64'(underrun_cnt), 64'd3);
`endif
        run("single_b", 6, 0, 1, -1, 0, -1, -1, 32'h1, 32'hC);
`ifdef HBM_CMD_UNPACK_CHK_EN
        chk(err_ch_mismatch == 1'b1, "err_sticky", 64'(err_ch_mismatch), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
